// File: rtl/spi_protocol.sv
// Single-master, three-slave SPI loopback: master and slave shift registers swap
// one byte over an internal SCLK/MOSI/MISO/SS_n bus in any CPOL/CPHA mode.
module spi_protocol (
    input  logic       start,
    input  logic       clk,
    input  logic [7:0] data_in_master,
    input  logic [7:0] data_in_slave,
    output logic [7:0] data_out_master,
    input  logic       load,
    output logic [7:0] data_out_slave,
    input  logic       CPOL,
    input  logic       CPHA,
    input  logic [1:0] Address,
    input  logic       reset1,
    input  logic       reset2,
    input  logic       reset3,
    input  logic       rst_n
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [0:0] state, state_nxt;
    logic [3:0] edge_cnt, edge_cnt_nxt;
    logic       sclk, sclk_nxt;
    logic [2:0] ss_n, ss_n_nxt;
    logic       cpol_q, cpol_nxt;
    logic       cpha_q, cpha_nxt;
    logic       mosi, mosi_nxt;
    logic       miso, miso_nxt;
    logic       master_hold, master_hold_nxt;
    logic       slave_hold, slave_hold_nxt;
    logic [7:0] master_reg, master_nxt;
    logic [7:0] slave_reg [3];
    logic [7:0] slave_nxt [3];
    logic [7:0] dout_slave_nxt;

    logic [2:0] slave_strobe;
    logic [2:0] addr_dec;
    logic       leading;
    logic       bus_bit7;
    logic       bus_bit6;
    logic       start_bit7;

    assign data_out_master = master_reg;
    assign slave_strobe    = {reset3, reset2, reset1};
    // Odd-numbered SCLK edges (edge_cnt even) are leading edges.
    assign leading         = ~edge_cnt[0];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            addr_dec[i] = (Address == 2'(i));
        end
    end

    // During a transfer the addressed slave is whichever one has SS_n low.
    always_comb begin
        bus_bit7 = 1'b0;
        bus_bit6 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!ss_n[i]) begin
                bus_bit7 = bus_bit7 | slave_reg[i][7];
                bus_bit6 = bus_bit6 | slave_reg[i][6];
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        edge_cnt_nxt    = edge_cnt;
        sclk_nxt        = sclk;
        ss_n_nxt        = ss_n;
        cpol_nxt        = cpol_q;
        cpha_nxt        = cpha_q;
        mosi_nxt        = mosi;
        miso_nxt        = miso;
        master_hold_nxt = master_hold;
        slave_hold_nxt  = slave_hold;
        master_nxt      = master_reg;
        start_bit7      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            slave_nxt[i] = slave_reg[i];
        end

        if (state == IDLE) begin
            sclk_nxt     = CPOL;
            ss_n_nxt     = 3'b111;
            edge_cnt_nxt = 4'd0;
            if (load) begin
                master_nxt = data_in_master;
            end
            for (int i = 0; i < 3; i++) begin
                if (slave_strobe[i]) begin
                    slave_nxt[i] = data_in_slave;
                end
            end
            // start is a single-cycle request: accepted on any IDLE edge where it
            // is high, after which it is ignored until the block is back in IDLE.
            if (start) begin
                for (int i = 0; i < 3; i++) begin
                    if (addr_dec[i]) begin
                        start_bit7 = start_bit7 | slave_nxt[i][7];
                    end
                end
                state_nxt = ACTIVE;
                cpol_nxt  = CPOL;
                cpha_nxt  = CPHA;
                ss_n_nxt  = ~addr_dec;
                mosi_nxt  = master_nxt[7];
                miso_nxt  = start_bit7;
            end
        end else begin
            sclk_nxt     = ~sclk;
            edge_cnt_nxt = edge_cnt + 4'd1;
            if (!cpha_q) begin
                if (leading) begin
                    master_hold_nxt = miso;
                    slave_hold_nxt  = mosi;
                end else begin
                    master_nxt = {master_reg[6:0], master_hold};
                    for (int i = 0; i < 3; i++) begin
                        if (!ss_n[i]) begin
                            slave_nxt[i] = {slave_reg[i][6:0], slave_hold};
                        end
                    end
                    mosi_nxt = master_reg[6];
                    miso_nxt = bus_bit6;
                end
            end else begin
                if (leading) begin
                    mosi_nxt = master_reg[7];
                    miso_nxt = bus_bit7;
                end else begin
                    master_nxt = {master_reg[6:0], miso};
                    for (int i = 0; i < 3; i++) begin
                        if (!ss_n[i]) begin
                            slave_nxt[i] = {slave_reg[i][6:0], mosi};
                        end
                    end
                end
            end
            if (edge_cnt == 4'd15) begin
                state_nxt    = IDLE;
                edge_cnt_nxt = 4'd0;
                sclk_nxt     = cpol_q;
                ss_n_nxt     = 3'b111;
            end
        end

        dout_slave_nxt = 8'h00;
        for (int i = 0; i < 3; i++) begin
            if (addr_dec[i]) begin
                dout_slave_nxt = slave_nxt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            edge_cnt       <= 4'd0;
            sclk           <= CPOL;
            ss_n           <= 3'b111;
            cpol_q         <= 1'b0;
            cpha_q         <= 1'b0;
            mosi           <= 1'b0;
            miso           <= 1'b0;
            master_hold    <= 1'b0;
            slave_hold     <= 1'b0;
            master_reg     <= 8'h00;
            slave_reg[0]   <= 8'h00;
            slave_reg[1]   <= 8'h00;
            slave_reg[2]   <= 8'h00;
            data_out_slave <= 8'h00;
        end else begin
            state          <= state_nxt;
            edge_cnt       <= edge_cnt_nxt;
            sclk           <= sclk_nxt;
            ss_n           <= ss_n_nxt;
            cpol_q         <= cpol_nxt;
            cpha_q         <= cpha_nxt;
            mosi           <= mosi_nxt;
            miso           <= miso_nxt;
            master_hold    <= master_hold_nxt;
            slave_hold     <= slave_hold_nxt;
            master_reg     <= master_nxt;
            slave_reg[0]   <= slave_nxt[0];
            slave_reg[1]   <= slave_nxt[1];
            slave_reg[2]   <= slave_nxt[2];
            data_out_slave <= dout_slave_nxt;
        end
    end

endmodule

// File: tb/tb_spi_protocol.sv
// Bench for spi_protocol: fixed mode table, hand-written abort/ignore sequences
// and randomized transfers against a byte-level swap model.
module tb_spi_protocol;

    logic       clk = 1'b0;
    logic       start, load, CPOL, CPHA, reset1, reset2, reset3, rst_n;
    logic [7:0] data_in_master, data_in_slave;
    logic [7:0] data_out_master, data_out_slave;
    logic [1:0] Address;

    always #5 clk = ~clk;

    spi_protocol dut (
        .start(start), .clk(clk), .data_in_master(data_in_master),
        .data_in_slave(data_in_slave), .data_out_master(data_out_master),
        .load(load), .data_out_slave(data_out_slave), .CPOL(CPOL), .CPHA(CPHA),
        .Address(Address), .reset1(reset1), .reset2(reset2), .reset3(reset3),
        .rst_n(rst_n)
    );

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic [1:0] addr;
        logic       ld;
        logic [7:0] dm;
        logic [2:0] strobes;
        logic [7:0] ds;
        logic [7:0] exp_m;
        logic [7:0] exp_s;
    } vec_t;

    vec_t       tbl [5];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q [$];
    logic [7:0] m_model;
    logic [7:0] s_model [3];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Reference model works on whole bytes: a transfer is a swap with the addressed slave.
    task automatic model_load(input logic ld, input logic [7:0] dm, input logic [2:0] strb,
                              input logic [7:0] ds);
        if (ld) m_model = dm;
        for (int i = 0; i < 3; i++) if (strb[i]) s_model[i] = ds;
    endtask

    task automatic model_xfer(input logic [1:0] addr);
        logic [7:0] tmp;
        if (addr == 2'd3) begin
            m_model = 8'h00;
        end else begin
            tmp           = m_model;
            m_model       = s_model[addr];
            s_model[addr] = tmp;
        end
    endtask

    function automatic logic [7:0] model_out(input logic [1:0] addr);
        return (addr == 2'd3) ? 8'h00 : s_model[addr];
    endfunction

    task automatic clear_strobes();
        start = 1'b0; load = 1'b0; reset1 = 1'b0; reset2 = 1'b0; reset3 = 1'b0;
    endtask

    task automatic run_transfer(input logic cpol, input logic cpha, input logic [1:0] addr,
                                input logic ld, input logic [7:0] dm, input logic [2:0] strb,
                                input logic [7:0] ds, input bit perturb,
                                input logic [1:0] addr_late);
        logic [7:0] got;
        @(negedge clk);
        CPOL = cpol; CPHA = cpha; Address = addr; load = ld; data_in_master = dm;
        {reset3, reset2, reset1} = strb; data_in_slave = ds; start = 1'b1;
        model_load(ld, dm, strb, ds);
        model_xfer(addr);
        @(posedge clk);
        #1;
        clear_strobes();
        data_in_master = 8'($urandom);
        data_in_slave  = 8'($urandom);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            check("sclk", {7'd0, dut.sclk}, {7'd0, cpol ^ k[0]});
            check("state", {7'd0, dut.state}, (k < 16) ? 8'd1 : 8'd0);
            if (perturb && k == 4) begin
                start = 1'b1; load = 1'b1; data_in_master = ~dm;
                reset1 = 1'b1; reset2 = 1'b1; reset3 = 1'b1;
                CPOL = ~cpol; CPHA = ~cpha;
            end
            if (perturb && k == 5) begin
                clear_strobes();
                CPOL = cpol; CPHA = cpha; Address = addr_late;
            end
        end
        exp_q.push_back(m_model);
        exp_q.push_back(model_out(Address));
        got = exp_q.pop_front();
        check("master_result", data_out_master, got);
        got = exp_q.pop_front();
        check("slave_result", data_out_slave, got);
    endtask

    task automatic read_slave(input logic [1:0] addr);
        @(negedge clk);
        Address = addr;
        @(posedge clk);
        #1;
        check($sformatf("slave_read%0d", addr), data_out_slave, model_out(addr));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 1'b0, 2'd0, 1'b1, 8'h36, 3'b001, 8'h4B, 8'h4B, 8'h36};
        tbl[1] = '{1'b0, 1'b1, 2'd1, 1'b0, 8'h00, 3'b010, 8'hB4, 8'hB4, 8'h4B};
        tbl[2] = '{1'b1, 1'b0, 2'd2, 1'b0, 8'h00, 3'b100, 8'h4E, 8'h4E, 8'hB4};
        tbl[3] = '{1'b1, 1'b1, 2'd0, 1'b0, 8'h00, 3'b000, 8'h00, 8'h36, 8'h4E};
        tbl[4] = '{1'b0, 1'b0, 2'd3, 1'b1, 8'hFF, 3'b000, 8'h00, 8'h00, 8'h00};

        rst_n = 1'b0; CPOL = 1'b0; CPHA = 1'b0; Address = 2'd0;
        data_in_master = 8'h00; data_in_slave = 8'h00;
        clear_strobes();
        m_model = 8'h00;
        for (int i = 0; i < 3; i++) s_model[i] = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        check("reset_master", data_out_master, 8'h00);
        check("reset_slave", data_out_slave, 8'h00);
        check("reset_state", {7'd0, dut.state}, 8'd0);
        check("reset_sclk", {7'd0, dut.sclk}, 8'd0);
        @(negedge clk);
        CPOL = 1'b1;
        @(posedge clk);
        #1;
        check("reset_sclk_cpol1", {7'd0, dut.sclk}, 8'd1);
        @(negedge clk);
        CPOL = 1'b0;
        rst_n = 1'b1;

        for (int t = 0; t < 5; t++) begin
            run_transfer(tbl[t].cpol, tbl[t].cpha, tbl[t].addr, tbl[t].ld, tbl[t].dm,
                         tbl[t].strobes, tbl[t].ds, 1'b0, tbl[t].addr);
            check($sformatf("tbl%0d_master", t), data_out_master, tbl[t].exp_m);
            check($sformatf("tbl%0d_slave", t), data_out_slave, tbl[t].exp_s);
        end
        for (int a = 0; a < 3; a++) read_slave(2'(a));

        // Strobes, mode bits and Address wiggled mid-transfer must not disturb the swap.
        run_transfer(1'b0, 1'b1, 2'd1, 1'b1, 8'hC3, 3'b010, 8'h3C, 1'b1, 2'd2);
        check("ignored_master", data_out_master, 8'h3C);
        repeat (3) @(posedge clk);
        #1;
        check("ignored_idle_state", {7'd0, dut.state}, 8'd0);
        check("ignored_idle_master", data_out_master, 8'h3C);
        for (int a = 0; a < 3; a++) read_slave(2'(a));

        // Abort: rst_n sampled low at cycle 8 of a transfer.
        @(negedge clk);
        CPOL = 1'b0; CPHA = 1'b0; Address = 2'd0; load = 1'b1; data_in_master = 8'hA5;
        reset1 = 1'b1; data_in_slave = 8'h5A; start = 1'b1;
        @(posedge clk);
        #1;
        clear_strobes();
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_model = 8'h00;
        for (int i = 0; i < 3; i++) s_model[i] = 8'h00;
        check("abort_master", data_out_master, 8'h00);
        check("abort_slave", data_out_slave, 8'h00);
        check("abort_state", {7'd0, dut.state}, 8'd0);
        for (int a = 0; a < 3; a++) read_slave(2'(a));

        for (int r = 0; r < 40; r++) begin
            run_transfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                         8'($urandom), 3'($urandom_range(0, 7)), 8'($urandom),
                         ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
        end
        for (int a = 0; a < 4; a++) read_slave(2'(a));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
